// File: rtl/decode_ctrl_pipe.sv
// ID-stage decoder and EX control register: load-use interlock, redirect flush,
// and multi-cycle EX hold for RV32M operations.
module decode_ctrl_pipe #(
    parameter bit          ENABLE_M   = 1'b0,
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        ex_redirect,
    output logic        ex_valid,
    output logic [17:0] ex_ctrl,
    output logic [4:0]  ex_rd,
    output logic        id_stall,
    output logic        id_flush,
    output logic        illegal,
    output logic        md_busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned REG_W = 5;

    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    typedef enum logic {RUN, MD_WAIT} state_e;

    typedef struct packed {
        logic [1:0] pc_src;
        logic       reg_write;
        logic       alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       b_type;
        logic       auipc;
        logic       jump;
        logic       md;
        logic       rsvd;
    } ctrl_t;

    logic [6:0]       opcode;
    logic [REG_W-1:0] rd;
    logic [2:0]       funct3;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [6:0]       funct7;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign funct7 = id_instr[31:25];

    ctrl_t dec_ctrl;
    logic  dec_legal;

    // Instruction decode; mem_to_reg: 00 ALU, 01 immediate, 10 pc+4, 11 load data.
    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b1;
        case (opcode)
            OP_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src_b  = 1'b1;
                dec_ctrl.mem_to_reg = 2'b11;
                dec_ctrl.mem_read   = 1'b1;
            end
            OP_STORE: begin
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.mem_write = 1'b1;
            end
            OP_IMM: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.alu_op    = {(funct3 == 3'b101) && funct7[5], funct3};
            end
            OP_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.b_type = ~funct3[0];
                dec_ctrl.alu_op = 4'b0100;
            end
            OP_JAL: begin
                dec_ctrl.pc_src     = 2'b10;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_to_reg = 2'b10;
                dec_ctrl.jump       = 1'b1;
            end
            OP_LUI: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_to_reg = 2'b01;
            end
            OP_REG: begin
                if ((funct7 == F7_BASE) || (funct7 == F7_ALT)) begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_op    = {funct7[5], funct3};
                end else if (ENABLE_M && (funct7 == F7_MD)) begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.md        = 1'b1;
                    dec_ctrl.alu_op    = {1'b0, funct3};
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OP_AUIPC: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.auipc     = 1'b1;
            end
            OP_JALR: begin
                dec_ctrl.pc_src     = 2'b01;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src_b  = 1'b1;
                dec_ctrl.mem_to_reg = 2'b10;
                dec_ctrl.jump       = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic rs1_used;
    logic rs2_used;

    // Source-register usage by opcode, independent of instruction legality.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: rs1_used = 1'b1;
            OP_STORE, OP_BRANCH, OP_REG: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] md_n;
    logic             ex_valid_q, ex_valid_d;
    ctrl_t            ex_ctrl_q, ex_ctrl_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             illegal_q, illegal_d;
    logic             md_busy_q, md_busy_d;
    logic             hazard;

    assign hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) && id_valid &&
                    ((rs1_used && (rs1 == ex_rd_q)) || (rs2_used && (rs2 == ex_rd_q)));

    // Next state: RUN prioritises redirect, then interlock, then issue.
    always_comb begin
        state_d    = state_q;
        md_cnt_d   = md_cnt_q;
        md_n       = '0;
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        illegal_d  = 1'b0;
        id_stall   = 1'b0;
        id_flush   = 1'b0;
        case (state_q)
            RUN: begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
                ex_rd_d    = '0;
                if (ex_redirect) begin
                    id_flush = 1'b1;
                end else if (hazard) begin
                    id_stall = 1'b1;
                end else if (id_valid) begin
                    if (dec_legal) begin
                        ex_valid_d = 1'b1;
                        ex_ctrl_d  = dec_ctrl;
                        ex_rd_d    = rd;
                        if (dec_ctrl.md) begin
                            md_n = funct3[2] ? DIV_N : MUL_N;
                            if (md_n > CNT_W'(1)) begin
                                state_d  = MD_WAIT;
                                md_cnt_d = md_n - CNT_W'(1);
                            end
                        end
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            MD_WAIT: begin
                // EX holds the M op; redirects cannot occur behind it.
                id_stall = 1'b1;
                md_cnt_d = md_cnt_q - CNT_W'(1);
                if (md_cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        md_busy_d = (state_d == MD_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            md_cnt_q   <= '0;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_rd_q    <= '0;
            illegal_q  <= 1'b0;
            md_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            md_cnt_q   <= md_cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            illegal_q  <= illegal_d;
            md_busy_q  <= md_busy_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_rd    = ex_rd_q;
    assign illegal  = illegal_q;
    assign md_busy  = md_busy_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: one instance without M (dut0), one with M and
// MUL=3/DIV=8 (dut1), sharing stimulus; directed scenarios plus random traffic.
module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_redirect;

    logic        ev [2];
    logic [17:0] ec [2];
    logic [4:0]  er [2];
    logic        st [2];
    logic        fl [2];
    logic        il [2];
    logic        mb [2];

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [31:0] I_LW_X5   = {12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] I_LW_X0   = {12'd0, 5'd2, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] I_ADD_X5  = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] I_ADD_X0  = {7'd0, 5'd1, 5'd0, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] I_BEQ     = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
    localparam logic [31:0] I_DIV     = {7'h01, 5'd2, 5'd1, 3'b100, 5'd7, 7'b0110011};
    localparam logic [31:0] I_MUL     = {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_ADDI    = {12'd1, 5'd0, 3'b000, 5'd9, 7'b0010011};

    // Expected control words, bit weights taken from the port bit map.
    localparam logic [17:0] C_LW   = 18'h0C340;
    localparam logic [17:0] C_ADD  = 18'h08000;
    localparam logic [17:0] C_BEQ  = 18'h01030;
    localparam logic [17:0] C_DIV  = 18'h09002;
    localparam logic [17:0] C_MUL  = 18'h08002;
    localparam logic [17:0] C_ADDI = 18'h0C000;

    always #5 clk = ~clk;

    decode_ctrl_pipe u_dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_redirect(ex_redirect), .ex_valid(ev[0]), .ex_ctrl(ec[0]), .ex_rd(er[0]),
        .id_stall(st[0]), .id_flush(fl[0]), .illegal(il[0]), .md_busy(mb[0])
    );

    decode_ctrl_pipe #(.ENABLE_M(1'b1), .MUL_CYCLES(3), .DIV_CYCLES(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_redirect(ex_redirect), .ex_valid(ev[1]), .ex_ctrl(ec[1]), .ex_rd(er[1]),
        .id_stall(st[1]), .id_flush(fl[1]), .illegal(il[1]), .md_busy(mb[1])
    );

    task automatic drive(input logic v, input logic [31:0] ins, input logic redir);
        @(negedge clk);
        id_valid    = v;
        id_instr    = ins;
        ex_redirect = redir;
        #1;
    endtask

    // Reference decode: control word as a sum of bit weights.
    function automatic logic [17:0] ref_ctrl(input logic [31:0] ins, input bit en_m, output bit ok);
        int c;
        int f3;
        int f7;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        ok = 1'b1;
        c  = 0;
        case (ins[6:0])
            7'b0000011: c = 'h0C340;
            7'b0100011: c = 'h04080;
            7'b0010011: c = 'h0C000 + (f3 + ((f3 == 5 && ins[30]) ? 8 : 0)) * 1024;
            7'b1100011: c = 'h01020 + (ins[12] ? 0 : 'h10);
            7'b1101111: c = 'h28204;
            7'b0110111: c = 'h08100;
            7'b0010111: c = 'h0C008;
            7'b1100111: c = 'h1C204;
            7'b0110011: begin
                if (f7 == 0 || f7 == 32) c = 'h08000 + (f3 + (f7 == 32 ? 8 : 0)) * 1024;
                else if (en_m && f7 == 1) c = 'h08002 + f3 * 1024;
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        return 18'(c);
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0010011 ||
               op == 7'b1100011 || op == 7'b0110011 || op == 7'b1100111;
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op == 7'b0100011 || op == 7'b1100011 || op == 7'b0110011;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7b;
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        f3  = 3'($urandom);
        imm = 12'($urandom);
        f7b = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 11))
            0:  return {imm, rs1, 3'b010, rd, 7'b0000011};
            1:  return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            2:  return {f7b, imm[4:0], rs1, f3, rd, 7'b0010011};
            3:  return {imm[11:5], rs2, rs1, 2'b00, f3[0], imm[4:0], 7'b1100011};
            4:  return {imm, imm[7:0], rd, 7'b1101111};
            5:  return {imm, imm[7:0], rd, 7'b0110111};
            6:  return {f7b, rs2, rs1, f3, rd, 7'b0110011};
            7:  return {7'h01, rs2, rs1, f3, rd, 7'b0110011};
            8:  return {imm, imm[7:0], rd, 7'b0010111};
            9:  return {imm, rs1, 3'b000, rd, 7'b1100111};
            10: return {7'h40, rs2, rs1, f3, rd, 7'b0110011};
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; ex_redirect = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({ev[k], ec[k], er[k], il[k], mb[k], st[k], fl[k]} !== 29'd0)
                $display("FAIL reset_outputs dut%0d: got %h exp 0", k,
                         {ev[k], ec[k], er[k], il[k], mb[k], st[k], fl[k]});
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        drive(1'b1, I_LW_X5, 1'b0);
        drive(1'b1, I_ADD_X5, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({st[k], fl[k], ev[k], ec[k], er[k]} !== {1'b1, 1'b0, 1'b1, C_LW, 5'd5})
                $display("FAIL lu_stall dut%0d: got st=%b fl=%b ev=%b ec=%h rd=%0d exp st=1 fl=0 ev=1 ec=%h rd=5",
                         k, st[k], fl[k], ev[k], ec[k], er[k], C_LW);
            else n_pass++;
        end
        drive(1'b1, I_ADD_X5, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({st[k], ev[k], ec[k]} !== {1'b0, 1'b0, 18'h0})
                $display("FAIL lu_bubble dut%0d: got st=%b ev=%b ec=%h exp st=0 ev=0 ec=0", k, st[k], ev[k], ec[k]);
            else n_pass++;
        end
        drive(1'b0, '0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({ev[k], ec[k], er[k]} !== {1'b1, C_ADD, 5'd6} || ec[k][13:10] !== 4'b0000)
                $display("FAIL lu_issue dut%0d: got ev=%b ec=%h rd=%0d exp ev=1 ec=%h rd=6", k, ev[k], ec[k], er[k], C_ADD);
            else n_pass++;
        end
    endtask

    task automatic test_x0_no_stall();
        drive(1'b1, I_LW_X0, 1'b0);
        drive(1'b1, I_ADD_X0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({st[k], ev[k], ec[k]} !== {1'b0, 1'b1, C_LW})
                $display("FAIL x0_stall dut%0d: got st=%b ev=%b ec=%h exp st=0 ev=1 ec=%h", k, st[k], ev[k], ec[k], C_LW);
            else n_pass++;
        end
        drive(1'b0, '0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({ev[k], ec[k], er[k]} !== {1'b1, C_ADD, 5'd6})
                $display("FAIL x0_issue dut%0d: got ev=%b ec=%h rd=%0d exp ev=1 ec=%h rd=6", k, ev[k], ec[k], er[k], C_ADD);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        drive(1'b1, I_BEQ, 1'b0);
        drive(1'b1, I_LW_X5, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({ev[k], ec[k]} !== {1'b1, C_BEQ})
                $display("FAIL beq_ctrl dut%0d: got ev=%b ec=%h exp ev=1 ec=%h", k, ev[k], ec[k], C_BEQ);
            else n_pass++;
        end
        drive(1'b1, I_ADD_X5, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({fl[k], st[k]} !== 2'b10)
                $display("FAIL redir_prio dut%0d: got fl=%b st=%b exp fl=1 st=0", k, fl[k], st[k]);
            else n_pass++;
        end
        drive(1'b0, '0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({ev[k], ec[k], il[k]} !== {1'b0, 18'h0, 1'b0})
                $display("FAIL redir_bubble dut%0d: got ev=%b ec=%h il=%b exp 0/0/0", k, ev[k], ec[k], il[k]);
            else n_pass++;
        end
    endtask

    task automatic test_mul_illegal();
        logic [3:0] exp_mb;
        logic [3:0] exp_ev;
        exp_mb = 4'b0011;
        exp_ev = 4'b0111;
        drive(1'b1, I_MUL, 1'b0);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, 1'b0);
            n_total++;
            if ({il[0], ev[0], ec[0]} !== {(c == 0), 1'b0, 18'h0})
                $display("FAIL mul_illegal c%0d: got il=%b ev=%b ec=%h exp il=%0d ev=0 ec=0", c, il[0], ev[0], ec[0], (c == 0));
            else n_pass++;
            n_total++;
            if ({ev[1], mb[1], il[1]} !== {exp_ev[c], exp_mb[c], 1'b0} || (exp_ev[c] && ec[1] !== C_MUL))
                $display("FAIL mul_hold c%0d: got ev=%b mb=%b il=%b ec=%h exp ev=%b mb=%b il=0 ec=%h",
                         c, ev[1], mb[1], il[1], ec[1], exp_ev[c], exp_mb[c], C_MUL);
            else n_pass++;
        end
    endtask

    task automatic test_div_hold();
        int held;
        int busy;
        int stall;
        held = 0; busy = 0; stall = 0;
        drive(1'b1, I_DIV, 1'b0);
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, I_ADDI, (c == 2));
            if (ev[1] && ec[1] === C_DIV && er[1] === 5'd7) held++;
            if (mb[1]) busy++;
            if (st[1]) stall++;
            if (c == 2) begin
                n_total++;
                if (fl[1] !== 1'b0) $display("FAIL div_redir_ignored: got fl=%b exp 0", fl[1]);
                else n_pass++;
            end
            if (c == 8) begin
                n_total++;
                if ({ev[1], ec[1], er[1]} !== {1'b1, C_ADDI, 5'd9})
                    $display("FAIL div_next_issue: got ev=%b ec=%h rd=%0d exp ev=1 ec=%h rd=9", ev[1], ec[1], er[1], C_ADDI);
                else n_pass++;
            end
        end
        n_total++;
        if (held != 8) $display("FAIL div_held_cycles: got %0d exp 8", held);
        else n_pass++;
        n_total++;
        if (busy != 7 || stall != 7) $display("FAIL div_busy_stall: got busy=%0d stall=%0d exp 7/7", busy, stall);
        else n_pass++;
    endtask

    task automatic test_reset_mdwait();
        drive(1'b1, I_DIV, 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        n_total++;
        if (mb[1] !== 1'b1) $display("FAIL rst_md_pre: got mb=%b exp 1", mb[1]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({ev[k], ec[k], er[k], il[k], mb[k], st[k], fl[k]} !== 29'd0)
                $display("FAIL rst_md_async dut%0d: got %h exp 0", k,
                         {ev[k], ec[k], er[k], il[k], mb[k], st[k], fl[k]});
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0);
        n_total++;
        if ({ev[1], mb[1], st[1]} !== 3'b000) $display("FAIL rst_md_release: got ev=%b mb=%b st=%b exp 000", ev[1], mb[1], st[1]);
        else n_pass++;
        drive(1'b1, I_ADDI, 1'b0);
        drive(1'b0, '0, 1'b0);
        n_total++;
        if ({ev[1], ec[1]} !== {1'b1, C_ADDI}) $display("FAIL rst_md_resume: got ev=%b ec=%h exp ev=1 ec=%h", ev[1], ec[1], C_ADDI);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        m_ev   [2];
        logic [17:0] m_ec   [2];
        logic [4:0]  m_er   [2];
        logic        m_il   [2];
        int          m_hold [2];
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_ev[k] = 1'b0; m_ec[k] = '0; m_er[k] = '0; m_il[k] = 1'b0; m_hold[k] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        v;
            logic        redir;
            logic [31:0] ins;
            v     = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 6) == 0);
            ins   = rand_instr();
            drive(v, ins, redir);
            for (int k = 0; k < 2; k++) begin
                bit          hz;
                bit          e_st;
                bit          e_fl;
                bit          e_mb;
                bit          ok;
                logic [17:0] c;
                hz = m_ev[k] && m_ec[k][6] && (m_er[k] != 0) && v &&
                     ((uses_rs1(ins[6:0]) && ins[19:15] == m_er[k]) ||
                      (uses_rs2(ins[6:0]) && ins[24:20] == m_er[k]));
                e_mb = (m_hold[k] > 0);
                e_fl = !e_mb && redir;
                e_st = e_mb || (!redir && hz);
                n_total++;
                if ({ev[k], il[k], mb[k], st[k], fl[k]} !== {m_ev[k], m_il[k], e_mb, e_st, e_fl})
                    $display("FAIL rand_flags dut%0d cyc%0d: got ev/il/mb/st/fl=%b exp %b", k, cyc,
                             {ev[k], il[k], mb[k], st[k], fl[k]}, {m_ev[k], m_il[k], e_mb, e_st, e_fl});
                else n_pass++;
                n_total++;
                if (ec[k] !== m_ec[k])
                    $display("FAIL rand_ctrl dut%0d cyc%0d: got %h exp %h", k, cyc, ec[k], m_ec[k]);
                else n_pass++;
                if (m_ev[k]) begin
                    n_total++;
                    if (er[k] !== m_er[k])
                        $display("FAIL rand_rd dut%0d cyc%0d: got %0d exp %0d", k, cyc, er[k], m_er[k]);
                    else n_pass++;
                end
                if (m_hold[k] > 0) begin
                    m_hold[k]--;
                    m_il[k] = 1'b0;
                end else begin
                    m_ev[k] = 1'b0; m_ec[k] = '0; m_er[k] = '0; m_il[k] = 1'b0;
                    if (!redir && !hz && v) begin
                        c = ref_ctrl(ins, (k == 1), ok);
                        if (ok) begin
                            m_ev[k] = 1'b1; m_ec[k] = c; m_er[k] = ins[11:7];
                            if (c[1]) m_hold[k] = (ins[14] ? 8 : 3) - 1;
                        end else begin
                            m_il[k] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_no_stall();
        test_redirect();
        test_mul_illegal();
        test_div_hold();
        test_reset_mdwait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter ENABLE_M, default 0, meaning 1 decodes RV32M mul/div (opcode 0110011, funct7 0000001) and 0 treats it as illegal.
REQ-002 SHALL have parameter MUL_CYCLES, default 3, meaning EX occupancy in cycles of a mul* op (legal range 1..15).
REQ-003 SHALL have parameter DIV_CYCLES, default 8, meaning EX occupancy in cycles of a div*/rem* op (legal range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port id_valid, input, 1, meaning id_instr holds a valid instruction.
REQ-007 SHALL have port id_instr, input, 32, meaning the ID-stage instruction word.
REQ-008 SHALL have port ex_redirect, input, 1, meaning EX resolved a taken branch or jump this cycle.
REQ-009 SHALL have port ex_valid, output, 1, registered, meaning the EX control bundle is live.
REQ-010 SHALL have port ex_ctrl, output, 18, registered, with bit map: [17:16] pc_src, [15] reg_write, [14] alu_src_b, [13:10] alu_op, [9:8] mem_to_reg, [7] mem_write, [6] mem_read, [5] branch, [4] b_type, [3] auipc, [2] jump, [1] md, [0] 0.
REQ-011 SHALL have port ex_rd, output, 5, registered, meaning the destination register of the EX instruction.
REQ-012 SHALL have port id_stall, output, 1, combinational, meaning hold the PC and the IF/ID register.
REQ-013 SHALL have port id_flush, output, 1, combinational, meaning squash the IF/ID content.
REQ-014 SHALL have port illegal, output, 1, registered one-cycle pulse marking an illegal instruction.
REQ-015 SHALL have port md_busy, output, 1, meaning state is MD_WAIT.

Function
REQ-016 SHALL decode the base set with the existing encodings: lw, sw, op-imm (addi/slti/xori/ori/andi/slli/srli/srai), beq/bne (alu_op XOR, b_type = ~funct3[0]), jal (pc_src 10, mem_to_reg 10), lui (mem_to_reg 01), R-type (alu_op = {funct7[5], funct3}), auipc, and jalr (pc_src 01).
REQ-017 SHALL decode an M op, when ENABLE_M=1, as reg_write=1, md=1, alu_op={0,funct3}; all other opcodes and funct7 values SHALL be illegal.
REQ-018 SHALL treat rs1 as used for opcodes 0000011, 0100011, 0010011, 1100011, 0110011 and 1100111, and rs2 as used for 0100011, 1100011 and 0110011.
REQ-019 SHALL detect a load-use hazard when ex_valid and ex_ctrl[6] are set, ex_rd != 0, id_valid is set, and a used rs of id_instr equals ex_rd.
REQ-020 SHALL implement the FSM states RUN and MD_WAIT, plus a 4-bit counter md_cnt.
REQ-021 SHALL apply this priority in RUN: ex_redirect first, then hazard, then issue.
- ex_redirect: id_flush=1, id_stall=0, next ex_valid=0, ex_ctrl=0.
- hazard: id_stall=1, bubble (ex_valid=0, ex_ctrl=0).
- issue with id_valid and a legal instruction: register the decode, ex_valid=1, ex_rd=instr[11:7].
- issue with id_valid and an illegal instruction: bubble, illegal=1 next cycle.
- no id_valid: bubble.
REQ-022 SHALL, on issuing an M op with cycle count N>1 (MUL_CYCLES if funct3[2]=0, else DIV_CYCLES), enter MD_WAIT with md_cnt=N-1; N=1 stays in RUN.
REQ-023 SHALL, in MD_WAIT, hold ex_valid, ex_ctrl and ex_rd unchanged, assert id_stall=1, and decrement md_cnt each cycle; when md_cnt=1 it SHALL return to RUN next cycle, so the op is presented for exactly N cycles.
REQ-024 SHALL ignore ex_redirect in MD_WAIT and keep id_flush=0 there.
REQ-025 SHALL keep id_flush equal to ex_redirect & (state==RUN).

Reset
REQ-026 SHALL, while rst_n=0 (asynchronous to clk), force state=RUN, md_cnt=0, ex_valid=0, ex_ctrl=0, ex_rd=0 and illegal=0; id_stall and id_flush then read 0.
REQ-027 SHALL, when reset is asserted during MD_WAIT, abandon the M op and resume with an empty EX on the first edge after release.

Verification
REQ-028 Bench SHALL issue lw x5 then add x6,x5,x1 back-to-back -> id_stall=1 for 1 cycle, one bubble, add issued the next cycle with ex_ctrl[13:10]=0000.
REQ-029 Bench SHALL issue lw x0 then add x6,x0,x1 -> no stall.
REQ-030 Bench SHALL issue beq, then assert ex_redirect together with a hazard condition -> id_flush=1, id_stall=0, bubble.
REQ-031 Bench SHALL, with ENABLE_M=1 and DIV_CYCLES=8, issue div -> ex_valid and ex_ctrl held 8 cycles, md_busy=1 for 7, id_stall=1 for 7.
REQ-032 Bench SHALL, with ENABLE_M=0, issue mul -> illegal pulses 1 cycle and ex_valid=0.
REQ-033 Bench SHALL drop rst_n mid-clock in MD_WAIT -> all outputs 0 immediately, md_busy=0.
